// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter merging NUM_REQ valid/ready requesters
// into a single FIFO write port, with packet lock and a MAX_BURST beat cap.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/last    - per-requester valid and last-beat flags
//   req_data          - packed requester data, i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         - per-requester accept
//   fifo_wr_en/data   - FIFO write strobe and word
//   fifo_wr_full      - FIFO full flag
//   grant_id, busy    - current grant holder (0 when idle), GRANT-state flag
// Optional: `define FIFO_ARB_TIMEOUT_EN releases a grant after TIMEOUT
// consecutive idle (no valid, not full) cycles of the holder.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);
  localparam logic [8:0] BURST_MAX = 9'(MAX_BURST);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
    $error("fifo_wr_arbiter: MAX_BURST out of range 1..256");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_wr_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_last;
  logic [8:0]       r_beats;

  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [IDW:0]     w_sum;
  logic [DATA_WIDTH-1:0] w_data;
  logic             w_grant;
  logic             w_active;
  logic             w_xfer;
  logic [8:0]       w_beats_inc;
  logic             w_burst_end;
  logic             w_release;
  logic             w_timeout;

  // Round-robin search starting one past the last holder.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDW+1)'(k);
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant     = (r_state == S_GRANT);
  assign w_xfer      = w_grant && req_valid[r_grant] && !fifo_wr_full;
  assign w_beats_inc = r_beats + 9'd1;
  assign w_burst_end = (w_beats_inc == BURST_MAX);
  assign w_release   = (w_xfer && (req_last[r_grant] || w_burst_end))
                     || w_timeout;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_inc;
  logic          w_idle_cnt;

  assign w_idle_cnt = w_grant && !req_valid[r_grant] && !fifo_wr_full;
  assign w_idle_inc = r_idle + IW'(1);
  assign w_timeout  = w_idle_cnt && (w_idle_inc == IW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (!w_grant || w_xfer || w_release) begin
      r_idle <= '0;
    end else if (w_idle_cnt) begin
      r_idle <= w_idle_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found)   w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IDW'(NUM_REQ - 1);
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_grant && w_found) begin
        r_grant <= w_pick;
        r_beats <= '0;
      end else if (w_xfer) begin
        r_beats <= w_beats_inc;
      end
      if (w_release) begin
        r_last <= r_grant;
      end
    end
  end

  // Outputs are masked by rst so a burst cut by reset writes nothing
  // in the reset cycle itself.
  assign w_active     = w_grant && !rst;
  assign busy         = w_active;
  assign grant_id     = w_active ? r_grant : '0;
  assign fifo_wr_en   = w_active && req_valid[r_grant] && !fifo_wr_full;
  assign fifo_wr_data = w_active ? w_data : '0;

  always_comb begin
    req_ready = '0;
    if (w_active && !fifo_wr_full) begin
      req_ready[r_grant] = 1'b1;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each requester data word and of the FIFO write word.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..16.
REQ-003 Parameter MAX_BURST, default 4: maximum beats accepted per grant, range 1..256.
REQ-004 Parameter TIMEOUT, default 16: idle cycles before a forced grant release; used only under FIFO_ARB_TIMEOUT_EN.
REQ-005 clk  input  1: single clock; all logic on its rising edge.
REQ-006 rst  input  1: reset, synchronous and active-high.
REQ-007 req_valid  input  NUM_REQ: per-requester data-valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last  input  NUM_REQ: per-requester last beat of packet, qualified by req_valid.
REQ-010 req_ready  output  NUM_REQ: per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both 1.
REQ-011 fifo_wr_en  output  1: write strobe to the FIFO write port.
REQ-012 fifo_wr_data  output  DATA_WIDTH: write data to the FIFO.
REQ-013 fifo_wr_full  input  1: FIFO full flag from the write domain.
REQ-014 grant_id  output  $clog2(NUM_REQ): index of the current grant holder; 0 when idle.
REQ-015 busy  output  1: 1 while in GRANT state.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT.
REQ-017 In IDLE with any req_valid bit set, the arbiter SHALL select the first set bit searching round-robin from last_grant+1 (mod NUM_REQ), latch it as grant_id, and enter GRANT on the next edge.
REQ-018 Arbitration latency SHALL be exactly one cycle; no beat transfers in IDLE.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal !fifo_wr_full; all other req_ready bits SHALL be 0.
REQ-020 fifo_wr_en SHALL be req_valid[grant_id] && !fifo_wr_full in GRANT, else 0; combinational, same cycle.
REQ-021 fifo_wr_data SHALL be the grant_id slice of req_data in GRANT, else 0.
REQ-022 A 9-bit beat counter SHALL clear on entering GRANT and increment on each transfer.
REQ-023 GRANT SHALL exit to IDLE on the edge following a transfer with req_last=1, or a transfer that brings the beat count to MAX_BURST, whichever occurs first; last_grant SHALL be updated to grant_id.
REQ-024 While the grant holder deasserts req_valid mid-packet, the grant SHALL be held (packet lock) and no other requester is served.
REQ-025 While fifo_wr_full=1, no transfer occurs, and the beat counter and state SHALL hold.
REQ-026 A requester granted on exit SHALL have lowest priority in the next arbitration.

Reset
REQ-027 With rst=1 at an edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), beat counter=0, idle counter=0.
REQ-028 During and immediately after reset, req_ready=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0.
REQ-029 Reset mid-burst SHALL abandon the burst; no write is issued in the reset cycle, and the partial packet is not resumed.

Configuration
REQ-030 Macro FIFO_ARB_TIMEOUT_EN defined: an idle counter SHALL count GRANT cycles with req_valid[grant_id]=0 and fifo_wr_full=0, clear on any transfer, and force exit to IDLE (last_grant updated) when it reaches TIMEOUT.
REQ-031 Macro FIFO_ARB_TIMEOUT_EN undefined: no idle counter; the grant is held indefinitely per REQ-024.

Verification
REQ-032 Reset, then req_valid=4'b0101, 1-beat packets (req_last=1) -> grants 0,2,0,2; each write appears 1 cycle after its grant; fifo_wr_data matches the source.
REQ-033 Requester 1 sends 6 beats with req_last on beat 6, MAX_BURST=4 -> 4 writes, IDLE, then re-grant of 1 (sole requester), 2 more writes.
REQ-034 fifo_wr_full=1 for 3 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those 3 cycles; beat count held; no data lost or duplicated.
REQ-035 rst asserted on the 2nd beat of a 4-beat grant -> fifo_wr_en=0 in the reset cycle, busy=0 afterwards, next grant goes to requester 0.
REQ-036 With FIFO_ARB_TIMEOUT_EN and TIMEOUT=16, holder drops req_valid after 1 beat -> release after 16 cycles, next requester granted; without the macro -> grant still held at 100 cycles.
